// File: rtl/dot_product_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_engine
//  Description : Streams VECTOR_WIDTH operand pairs per vector from two
//                lock-step memories, accumulates the unsigned products and
//                hands each dot product downstream with a valid/ready hold.
//  Revision    : 1.0  initial release
// ============================================================================
module dot_product_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   vec_count,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_a_data,
  input  logic [DATA_WIDTH-1:0]   mem_b_data,
  output logic [RESULT_WIDTH-1:0] dot_product_result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    processing_done,
  output logic                    busy
);

  localparam int                    ELEM_W    = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [ELEM_W-1:0]     ELEM_LAST = ELEM_W'(VECTOR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(VECTOR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;      // latched vec_count
  logic [ADDR_WIDTH-1:0]   vidx_q, vidx_d;    // current vector index
  logic [ELEM_W-1:0]       elem_q, elem_d;    // element index within vector
  logic [ADDR_WIDTH-1:0]   base_q, base_d;    // base address of current vector
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic                    rd_pend_q;         // read issued last cycle, data now present
  logic                    first_q;           // that read was element 0 of its vector

  logic [2*DATA_WIDTH-1:0] prod;
  logic [RESULT_WIDTH-1:0] sum;
  logic [ADDR_WIDTH:0]     vidx_next_ext;

  // Full-width unsigned product; the first product of a vector overwrites the accumulator
  assign prod = {{DATA_WIDTH{1'b0}}, mem_a_data} * {{DATA_WIDTH{1'b0}}, mem_b_data};
  assign sum  = first_q ? RESULT_WIDTH'(prod) : acc_q + RESULT_WIDTH'(prod);
  assign vidx_next_ext = {1'b0, vidx_q} + (ADDR_WIDTH+1)'(1);

  assign mem_rd_en          = (state_q == S_READ);
  assign mem_rd_addr        = (state_q == S_READ) ? base_q + ADDR_WIDTH'(elem_q) : '0;
  assign dot_product_result = result_q;
  assign result_valid       = (state_q == S_EMIT);
  assign processing_done    = (state_q == S_DONE);
  assign busy               = (state_q != S_IDLE);

  // Next-state and datapath update decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vidx_d   = vidx_q;
    elem_d   = elem_q;
    base_d   = base_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (rd_pend_q) begin
      acc_d = sum;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = vec_count;
          vidx_d  = '0;
          elem_d  = '0;
          acc_d   = '0;
          base_d  = '0;
          state_d = (vec_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        elem_d = elem_q + ELEM_W'(1);
        if (elem_q == ELEM_LAST) begin
          elem_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last product arrives this cycle; fold it straight into the result
        result_d = sum;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (result_ready) begin
          if (vidx_next_ext < {1'b0, cnt_q}) begin
            vidx_d  = vidx_q + ADDR_WIDTH'(1);
            base_d  = base_q + BASE_STEP;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vidx_q    <= '0;
      elem_q    <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      rd_pend_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vidx_q    <= vidx_d;
      elem_q    <= elem_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      rd_pend_q <= (state_q == S_READ);
      first_q   <= (state_q == S_READ) && (elem_q == '0);
    end
  end

endmodule
`default_nettype wire
